// File: rtl/player_sequencer.sv
// -----------------------------------------------------------------------------
// player_sequencer
//
// Frame-rate controller for the player datapath. Raw controller buttons are
// accumulated between frame ticks and, once per frame, turned into paced
// one-cycle step commands and timed sword attacks. The block also owns player
// health, post-hit invulnerability, pause and the sticky game-over condition.
//
// Ports
//   clk            system clock, all registers on its rising edge
//   reset          synchronous, active-high reset
//   frame_tick     one-cycle pulse per video frame; all pacing decisions
//   A, B           attack buttons (level)
//   start          pause toggle button (level)
//   up/down/left/right  direction buttons (level)
//   player_hit     one-cycle damage pulse from collision logic
//   step_valid     one-cycle command: move the player one tile
//   step_dir       step direction (00 up, 01 right, 10 down, 11 left)
//   sword_active   sword is shown in front of the player (level)
//   sword_dir      sword direction, held while sword_active is low
//   facing         last commanded orientation
//   player_health  remaining health, 3 down to 0
//   invuln         hit immunity active
//   paused         game paused
//   game_over      sticky, player is dead
// -----------------------------------------------------------------------------
module player_sequencer #(
  parameter int MOVE_PERIOD     = 8,
  parameter int ATTACK_FRAMES   = 4,
  parameter int COOLDOWN_FRAMES = 6,
  parameter int INVULN_FRAMES   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       A,
  input  logic       B,
  input  logic       start,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       player_hit,
  output logic       step_valid,
  output logic [1:0] step_dir,
  output logic       sword_active,
  output logic [1:0] sword_dir,
  output logic [1:0] facing,
  output logic [1:0] player_health,
  output logic       invuln,
  output logic       paused,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE_WAIT = 3'd1,
    S_ATTACK    = 3'd2,
    S_COOLDOWN  = 3'd3,
    S_DEAD      = 3'd4
  } state_t;

  // Bit positions inside the packed button vector.
  localparam int BTN_A     = 6;
  localparam int BTN_B     = 5;
  localparam int BTN_START = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;
  localparam int NUM_BTN   = 7;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [5:0] MOVE_RELOAD   = 6'(MOVE_PERIOD - 1);
  localparam logic [5:0] ATTACK_LOAD   = 6'(ATTACK_FRAMES);
  localparam logic [5:0] COOLDOWN_LOAD = 6'(COOLDOWN_FRAMES);
  localparam logic [5:0] INVULN_LOAD   = 6'(INVULN_FRAMES);

  // ---------------------------------------------------------------------------
  // Button latch: short presses between two ticks must not be lost, so every
  // cycle ORs the buttons in; the tick consumes latch|buttons and clears it.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] buttons;
  logic [NUM_BTN-1:0] latch_reg;
  logic [NUM_BTN-1:0] seen;

  assign buttons = {A, B, start, up, down, left, right};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_seen
      assign seen[gi] = latch_reg[gi] | buttons[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_reg <= '0;
    end else if (frame_tick) begin
      latch_reg <= '0;
    end else begin
      latch_reg <= seen;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the frame's accumulated buttons.
  // ---------------------------------------------------------------------------
  logic       attack_req;
  logic       dir_any;
  logic [1:0] dir_code;
  logic [1:0] attack_dir;

  assign attack_req = seen[BTN_A] | seen[BTN_B];
  assign dir_any    = seen[BTN_UP] | seen[BTN_DOWN] | seen[BTN_LEFT] | seen[BTN_RIGHT];

  // Priority: up > down > left > right.
  always_comb begin
    dir_code = DIR_RIGHT;
    if (seen[BTN_UP]) begin
      dir_code = DIR_UP;
    end else if (seen[BTN_DOWN]) begin
      dir_code = DIR_DOWN;
    end else if (seen[BTN_LEFT]) begin
      dir_code = DIR_LEFT;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state and outputs.
  // ---------------------------------------------------------------------------
  state_t     state_reg,         state_next;
  logic [5:0] cnt_reg,           cnt_next;
  logic [5:0] inv_cnt_reg,       inv_cnt_next;
  logic       step_valid_reg,    step_valid_next;
  logic [1:0] step_dir_reg,      step_dir_next;
  logic       sword_active_reg,  sword_active_next;
  logic [1:0] sword_dir_reg,     sword_dir_next;
  logic [1:0] facing_reg,        facing_next;
  logic [1:0] health_reg,        health_next;
  logic       invuln_reg,        invuln_next;
  logic       paused_reg,        paused_next;
  logic       game_over_reg,     game_over_next;

  // An attack without a direction keeps the current orientation.
  assign attack_dir = dir_any ? dir_code : facing_reg;

  // Qualifiers shared by the next-state logic.
  logic pause_toggle;
  logic hit_accept;
  logic dying;
  logic frame_live;
  logic run_tick;

  assign pause_toggle = frame_tick & seen[BTN_START] & (state_reg != S_DEAD);
  assign hit_accept   = player_hit & ~invuln_reg & (health_reg != 2'd0) & ~paused_reg;
  assign dying        = hit_accept & (health_reg == 2'd1);
  // The tick that toggles pause is consumed by the toggle itself and does not
  // count as a frame for the state machine or the invulnerability timer.
  assign frame_live   = frame_tick & ~paused_reg & ~pause_toggle;
  // A fatal hit overrides whatever the frame decision would have been.
  assign run_tick     = frame_live & ~dying & (state_reg != S_DEAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= 6'd0;
      inv_cnt_reg      <= 6'd0;
      step_valid_reg   <= 1'b0;
      step_dir_reg     <= DIR_UP;
      sword_active_reg <= 1'b0;
      sword_dir_reg    <= DIR_RIGHT;
      facing_reg       <= DIR_RIGHT;
      health_reg       <= 2'd3;
      invuln_reg       <= 1'b0;
      paused_reg       <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      inv_cnt_reg      <= inv_cnt_next;
      step_valid_reg   <= step_valid_next;
      step_dir_reg     <= step_dir_next;
      sword_active_reg <= sword_active_next;
      sword_dir_reg    <= sword_dir_next;
      facing_reg       <= facing_next;
      health_reg       <= health_next;
      invuln_reg       <= invuln_next;
      paused_reg       <= paused_next;
      game_over_reg    <= game_over_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: frame decision, pause, damage and death.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    inv_cnt_next      = inv_cnt_reg;
    step_valid_next   = 1'b0;
    step_dir_next     = step_dir_reg;
    sword_active_next = sword_active_reg;
    sword_dir_next    = sword_dir_reg;
    facing_next       = facing_reg;
    health_next       = health_reg;
    invuln_next       = invuln_reg;
    paused_next       = paused_reg;
    game_over_next    = game_over_reg;

    if (pause_toggle) begin
      paused_next = ~paused_reg;
    end

    if (run_tick) begin
      unique case (state_reg)
        S_IDLE: begin
          if (attack_req) begin
            state_next        = S_ATTACK;
            cnt_next          = ATTACK_LOAD;
            sword_active_next = 1'b1;
            sword_dir_next    = attack_dir;
            facing_next       = attack_dir;
          end else if (dir_any) begin
            step_valid_next = 1'b1;
            step_dir_next   = dir_code;
            facing_next     = dir_code;
            // With a one-frame period there is nothing to wait for.
            if (MOVE_PERIOD > 1) begin
              state_next = S_MOVE_WAIT;
              cnt_next   = MOVE_RELOAD;
            end
          end
        end

        S_MOVE_WAIT: begin
          // Attack preempts movement pacing; direction presses are dropped.
          if (attack_req) begin
            state_next        = S_ATTACK;
            cnt_next          = ATTACK_LOAD;
            sword_active_next = 1'b1;
            sword_dir_next    = attack_dir;
            facing_next       = attack_dir;
          end else if (cnt_reg == 6'd1) begin
            state_next = S_IDLE;
          end else begin
            cnt_next = cnt_reg - 6'd1;
          end
        end

        S_ATTACK: begin
          if (cnt_reg == 6'd1) begin
            state_next        = S_COOLDOWN;
            cnt_next          = COOLDOWN_LOAD;
            sword_active_next = 1'b0;
          end else begin
            cnt_next = cnt_reg - 6'd1;
          end
        end

        S_COOLDOWN: begin
          if (cnt_reg == 6'd1) begin
            state_next = S_IDLE;
          end else begin
            cnt_next = cnt_reg - 6'd1;
          end
        end

        default: begin
          state_next = state_reg;
        end
      endcase
    end

    // Damage is evaluated every cycle, independent of the frame decision.
    if (hit_accept) begin
      health_next  = health_reg - 2'd1;
      invuln_next  = 1'b1;
      inv_cnt_next = INVULN_LOAD;
    end else if (frame_live && invuln_reg) begin
      inv_cnt_next = inv_cnt_reg - 6'd1;
      if (inv_cnt_reg == 6'd1) begin
        invuln_next = 1'b0;
      end
    end

    if (dying) begin
      state_next        = S_DEAD;
      game_over_next    = 1'b1;
      sword_active_next = 1'b0;
      paused_next       = 1'b0;
      step_valid_next   = 1'b0;
    end
  end

  assign step_valid    = step_valid_reg;
  assign step_dir      = step_dir_reg;
  assign sword_active  = sword_active_reg;
  assign sword_dir     = sword_dir_reg;
  assign facing        = facing_reg;
  assign player_health = health_reg;
  assign invuln        = invuln_reg;
  assign paused        = paused_reg;
  assign game_over     = game_over_reg;

endmodule

// File: tb/tb_player_sequencer.sv
module tb_player_sequencer;

  localparam int MOVE_P = 8;
  localparam int ATT_F  = 4;
  localparam int COOL_F = 6;
  localparam int INV_F  = 32;

  // Button vector order: {A, B, start, up, down, left, right}
  localparam logic [6:0] K_NONE  = 7'b0000000;
  localparam logic [6:0] K_RIGHT = 7'b0000001;
  localparam logic [6:0] K_LEFT  = 7'b0000010;
  localparam logic [6:0] K_UP    = 7'b0001000;
  localparam logic [6:0] K_START = 7'b0010000;
  localparam logic [6:0] K_B     = 7'b0100000;
  localparam logic [6:0] K_A     = 7'b1000000;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       A, B, start, up, down, left, right;
  logic       player_hit;
  logic       step_valid;
  logic [1:0] step_dir;
  logic       sword_active;
  logic [1:0] sword_dir;
  logic [1:0] facing;
  logic [1:0] player_health;
  logic       invuln;
  logic       paused;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  player_sequencer #(
    .MOVE_PERIOD    (MOVE_P),
    .ATTACK_FRAMES  (ATT_F),
    .COOLDOWN_FRAMES(COOL_F),
    .INVULN_FRAMES  (INV_F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .A            (A),
    .B            (B),
    .start        (start),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .player_hit   (player_hit),
    .step_valid   (step_valid),
    .step_dir     (step_dir),
    .sword_active (sword_active),
    .sword_dir    (sword_dir),
    .facing       (facing),
    .player_health(player_health),
    .invuln       (invuln),
    .paused       (paused),
    .game_over    (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Reference model: tracks "frames remaining" for each activity rather than
  // a state register; outputs follow directly from those budgets.
  // ---------------------------------------------------------------------------
  logic [6:0] m_pending;
  int         m_attack_left, m_cool_left, m_wait_left, m_inv_left, m_health;
  bit         m_dead, m_paused;
  bit         e_sv, e_sa;
  logic [1:0] e_sd, e_swd, e_f;

  function automatic logic [1:0] pick_dir(input logic [6:0] s);
    if (s[3]) return 2'd0;
    if (s[2]) return 2'd2;
    if (s[1]) return 2'd3;
    return 2'd1;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [6:0] b, input logic h);
    logic [6:0] s;
    bit toggle, dmg, dies, live, run, atk, has_dir;
    logic [1:0] d;
    if (r) begin
      m_pending = '0; m_attack_left = 0; m_cool_left = 0; m_wait_left = 0;
      m_inv_left = 0; m_health = 3; m_dead = 0; m_paused = 0;
      e_sv = 0; e_sa = 0; e_sd = 2'd0; e_swd = 2'd1; e_f = 2'd1;
      return;
    end
    s = m_pending | b;
    m_pending = t ? 7'd0 : s;
    e_sv   = 0;
    toggle = t && s[4] && !m_dead;
    dmg    = h && (m_inv_left == 0) && (m_health > 0) && !m_paused;
    dies   = dmg && (m_health == 1);
    live   = t && !m_paused && !toggle;
    run    = live && !dies && !m_dead;
    atk    = s[6] | s[5];
    has_dir = |s[3:0];
    d      = pick_dir(s);
    if (run) begin
      if (m_attack_left > 0) begin
        m_attack_left--;
        if (m_attack_left == 0) begin
          m_cool_left = COOL_F;
          e_sa = 0;
        end
      end else if (m_cool_left > 0) begin
        m_cool_left--;
      end else if (atk) begin
        m_attack_left = ATT_F;
        m_wait_left = 0;
        e_swd = has_dir ? d : e_f;
        e_f   = e_swd;
        e_sa  = 1;
      end else if (m_wait_left > 0) begin
        m_wait_left--;
      end else if (has_dir) begin
        e_sv = 1;
        e_sd = d;
        e_f  = d;
        m_wait_left = MOVE_P - 1;
      end
    end
    if (toggle) m_paused = !m_paused;
    if (dmg) begin
      m_health--;
      m_inv_left = INV_F;
    end else if (live && m_inv_left > 0) begin
      m_inv_left--;
    end
    if (dies) begin
      m_dead = 1; e_sa = 0; m_paused = 0;
    end
  endtask

  function automatic logic [12:0] pk(input logic sv, input logic [1:0] sd, input logic sa,
                                     input logic [1:0] swd, input logic [1:0] f, input logic [1:0] hp,
                                     input logic inv, input logic p, input logic go);
    return {sv, sd, sa, swd, f, hp, inv, p, go};
  endfunction

  function automatic logic [12:0] model_vec();
    return pk(e_sv, e_sd, e_sa, e_swd, e_f, 2'(m_health), m_inv_left > 0, m_paused, m_dead);
  endfunction

  function automatic logic [12:0] dut_vec();
    return pk(step_valid, step_dir, sword_active, sword_dir, facing, player_health,
              invuln, paused, game_over);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance model, sample 1 ns after the edge.
  task automatic do_cycle(input logic r, input logic t, input logic [6:0] b, input logic h);
    reset = r;
    frame_tick = t;
    {A, B, start, up, down, left, right} = b;
    player_hit = h;
    model_step(r, t, b, h);
    @(posedge clk);
    #1;
    chk("model", 16'(dut_vec()), 16'(model_vec()));
  endtask

  typedef struct {
    logic        rst;
    logic        tick;
    logic [6:0]  btn;
    logic        hit;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic [12:0] rv;
    reset = 1'b1; frame_tick = 1'b0; player_hit = 1'b0;
    {A, B, start, up, down, left, right} = 7'd0;

    rv = pk(0, 2'd0, 0, 2'd1, 2'd1, 2'd3, 0, 0, 0);
    vecs[0]  = '{1, 0, K_NONE,        0, rv};
    vecs[1]  = '{0, 1, K_RIGHT,       0, pk(1, 2'd1, 0, 2'd1, 2'd1, 2'd3, 0, 0, 0)};
    vecs[2]  = '{0, 0, K_NONE,        0, pk(0, 2'd1, 0, 2'd1, 2'd1, 2'd3, 0, 0, 0)};
    vecs[3]  = '{0, 1, K_UP,          0, pk(0, 2'd1, 0, 2'd1, 2'd1, 2'd3, 0, 0, 0)};
    vecs[4]  = '{1, 0, K_NONE,        0, rv};
    vecs[5]  = '{0, 0, K_UP,          0, rv};
    vecs[6]  = '{0, 1, K_NONE,        0, pk(1, 2'd0, 0, 2'd1, 2'd0, 2'd3, 0, 0, 0)};
    vecs[7]  = '{1, 0, K_NONE,        0, rv};
    vecs[8]  = '{0, 1, K_A | K_LEFT,  0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 0, 0)};
    vecs[9]  = '{0, 1, K_NONE,        0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 0, 0)};
    vecs[10] = '{0, 1, K_START,       0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 1, 0)};
    vecs[11] = '{0, 0, K_NONE,        1, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 1, 0)};
    vecs[12] = '{0, 1, K_NONE,        0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 1, 0)};
    vecs[13] = '{0, 1, K_START,       0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 0, 0)};
    vecs[14] = '{0, 1, K_NONE,        0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 0, 0)};
    vecs[15] = '{0, 1, K_NONE,        0, pk(0, 2'd0, 1, 2'd3, 2'd3, 2'd3, 0, 0, 0)};
    vecs[16] = '{0, 1, K_NONE,        0, pk(0, 2'd0, 0, 2'd3, 2'd3, 2'd3, 0, 0, 0)};
    vecs[17] = '{0, 0, K_NONE,        1, pk(0, 2'd0, 0, 2'd3, 2'd3, 2'd2, 1, 0, 0)};
    vecs[18] = '{0, 0, K_NONE,        1, pk(0, 2'd0, 0, 2'd3, 2'd3, 2'd2, 1, 0, 0)};
    vecs[19] = '{1, 1, K_A,           1, rv};
    vecs[20] = '{0, 1, K_B,           0, pk(0, 2'd0, 1, 2'd1, 2'd1, 2'd3, 0, 0, 0)};
    vecs[21] = '{1, 0, K_NONE,        0, rv};

    // Table-driven vectors.
    for (int i = 0; i < 22; i++) begin
      do_cycle(vecs[i].rst, vecs[i].tick, vecs[i].btn, vecs[i].hit);
      chk($sformatf("vec%0d", i), 16'(dut_vec()), 16'(vecs[i].exp));
    end

    // Held right for 17 ticks: steps after ticks 0, 8 and 16 only.
    do_cycle(1, 0, K_NONE, 0);
    for (int i = 0; i < 17; i++) begin
      do_cycle(0, 1, K_RIGHT, 0);
      chk($sformatf("hold_step_t%0d", i), 16'(step_valid), 16'(i % MOVE_P == 0));
      if (i % MOVE_P == 0) begin
        chk("hold_step_dir", 16'(step_dir), 16'd1);
        chk("hold_facing", 16'(facing), 16'd1);
      end
      do_cycle(0, 0, K_RIGHT, 0);
      chk("step_one_cycle", 16'(step_valid), 16'd0);
    end

    // Attack with left held, then no step until cooldown has elapsed.
    do_cycle(1, 0, K_NONE, 0);
    do_cycle(0, 1, K_A | K_LEFT, 0);
    chk("atk_active", 16'(sword_active), 16'd1);
    chk("atk_dir", 16'(sword_dir), 16'd3);
    for (int i = 1; i <= ATT_F + COOL_F + 1; i++) begin
      do_cycle(0, 1, K_LEFT, 0);
      chk($sformatf("atk_sword_t%0d", i), 16'(sword_active), 16'(i < ATT_F));
      chk($sformatf("atk_step_t%0d", i), 16'(step_valid), 16'(i == ATT_F + COOL_F + 1));
    end
    chk("post_cool_dir", 16'(step_dir), 16'd3);

    // Three hits 40 ticks apart; invulnerability window and death.
    do_cycle(1, 0, K_NONE, 0);
    for (int hnum = 1; hnum <= 3; hnum++) begin
      do_cycle(0, 0, K_NONE, 1);
      chk($sformatf("hit%0d_health", hnum), 16'(player_health), 16'(3 - hnum));
      chk($sformatf("hit%0d_go", hnum), 16'(game_over), 16'(hnum == 3));
      if (hnum < 3) begin
        for (int i = 1; i <= 40; i++) begin
          do_cycle(0, 1, K_NONE, 0);
          if (i == 10) begin
            do_cycle(0, 0, K_NONE, 1);
            chk("hit_in_window", 16'(player_health), 16'(3 - hnum));
          end
          if (i == INV_F - 1) chk("invuln_still", 16'(invuln), 16'd1);
          if (i == INV_F)     chk("invuln_clear", 16'(invuln), 16'd0);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      do_cycle(0, 1, (i % 2 == 0) ? K_A : K_UP, (i == 5));
      chk("dead_no_step", 16'(step_valid), 16'd0);
      chk("dead_no_sword", 16'(sword_active), 16'd0);
    end
    chk("dead_health", 16'(player_health), 16'd0);
    chk("dead_sticky", 16'(game_over), 16'd1);

    // Randomized traffic against the model.
    do_cycle(1, 0, K_NONE, 0);
    for (int c = 0; c < 6000; c++) begin
      logic [6:0] b;
      b[6] = ($urandom_range(0, 9) == 0);
      b[5] = ($urandom_range(0, 14) == 0);
      b[4] = ($urandom_range(0, 39) == 0);
      b[3] = ($urandom_range(0, 5) == 0);
      b[2] = ($urandom_range(0, 5) == 0);
      b[1] = ($urandom_range(0, 5) == 0);
      b[0] = ($urandom_range(0, 3) == 0);
      do_cycle($urandom_range(0, 699) == 0, $urandom_range(0, 2) == 0, b,
               $urandom_range(0, 59) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
